fifo_word_packer: RTL and testbench

//  Downstream consumer of the 8-bit synchronous FIFO. Pops bytes via rd_en/empty, packs BYTES

---
 rtl/fifo_word_packer_pkg.sv | 15 +
 rtl/fifo_word_packer_if.sv | 26 ++
 rtl/fifo_word_packer_out_slot.sv | 42 ++++
 rtl/fifo_word_packer.sv | 120 ++++++++++++
 tb/tb_fifo_word_packer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and FSM encoding for the FIFO byte-to-word packer.
// The FIFO geometry defaults are kept here so the FIFO and the packer agree on byte width.
package fifo_word_packer_pkg;

  localparam int unsigned FifoWidth    = 8;
  localparam int unsigned FifoDepth    = 16;
  localparam int unsigned FifoPtrWidth = 4;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StDrain = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Valid/ready word stream carrying a packed word and its per-byte enable mask.
interface fifo_word_packer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BYTES = 4
);

  logic [WIDTH*BYTES-1:0] word;
  logic [BYTES-1:0]       byte_en;
  logic                   valid;
  logic                   ready;

  modport master (
    output word,
    output byte_en,
    output valid,
    input  ready
  );

  modport slave (
    input  word,
    input  byte_en,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fifo_word_packer_out_slot.sv
// Single-entry valid/ready holding register. The producer only loads it when it is free,
// so a load always wins over an acceptance in the same cycle.
module fifo_word_packer_out_slot #(
  parameter int unsigned DataWidth = 36
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a synchronous FIFO, packs BYTES of them little-endian into a word and
// hands the word to a valid/ready slot; flush_i pushes out a partially filled word.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = FifoWidth,
  parameter int unsigned BYTES     = 4,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  input  logic             flush_i,
  fifo_word_packer_if.master out_io
);

  localparam int unsigned WordWidth = WIDTH * BYTES;
  localparam int unsigned SlotWidth = WordWidth + BYTES;
  localparam logic [CNT_WIDTH:0] BytesCnt = (CNT_WIDTH + 1)'(BYTES);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [WordWidth-1:0]   asm_q, asm_d;

  logic [CNT_WIDTH:0]     fill_lvl;
  logic                   slot_free;
  logic                   load;
  logic [WordWidth-1:0]   word_masked;
  logic [BYTES-1:0]       byte_mask;
  logic [SlotWidth-1:0]   slot_data;

  // Bytes already captured plus the one whose read data arrives this cycle.
  assign fill_lvl  = {1'b0, count_q} + {{CNT_WIDTH{1'b0}}, rd_pend_q};
  assign slot_free = !out_io.valid || out_io.ready;

  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && (state_q == StFill) && (fill_lvl < BytesCnt);

  always_comb begin
    byte_mask   = '0;
    word_masked = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      byte_mask[k] = (count_q > CNT_WIDTH'(k));
      word_masked[k*WIDTH +: WIDTH] = byte_mask[k] ? asm_q[k*WIDTH +: WIDTH] : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    asm_d     = asm_q;
    rd_pend_d = fifo_rd_en_o;
    load      = 1'b0;

    if (rd_pend_q) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (count_q == CNT_WIDTH'(k)) begin
          asm_d[k*WIDTH +: WIDTH] = fifo_rdata_i;
        end
      end
      count_d = fill_lvl[CNT_WIDTH-1:0];
    end

    case (state_q)
      StFill: begin
        // A word completing this cycle takes priority over a flush.
        if (fill_lvl == BytesCnt) begin
          state_d = StFull;
        end else if (flush_i && (fill_lvl != '0)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!rd_pend_q) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (slot_free) begin
          load    = 1'b1;
          count_d = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFill;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      asm_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      asm_q     <= asm_d;
    end
  end

  fifo_word_packer_out_slot #(
    .DataWidth (SlotWidth)
  ) u_out_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .data_i  ({byte_mask, word_masked}),
    .ready_i (out_io.ready),
    .valid_o (out_io.valid),
    .data_o  (slot_data)
  );

  assign out_io.word    = slot_data[WordWidth-1:0];
  assign out_io.byte_en = slot_data[WordWidth +: BYTES];

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench: a 16-deep behavioural FIFO feeding fifo_word_packer, with a table of single-word
// vectors plus hand sequences for back-pressure, flush-during-pop and mid-word reset.
module tb_fifo_word_packer;
  import fifo_word_packer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fifo_rst, wr_en, flush;
  logic [7:0] wr_data;
  logic       fifo_empty, rd_en, fifo_pop;
  logic [7:0] fifo_rdata;

  fifo_word_packer_if #(.WIDTH(8), .BYTES(4)) out_if ();

  fifo_word_packer #(
    .WIDTH     (8),
    .BYTES     (4),
    .CNT_WIDTH (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rd_en_o (rd_en),
    .flush_i      (flush),
    .out_io       (out_if)
  );

  // Behavioural synchronous FIFO: read data valid the cycle after a pop.
  logic [7:0]              mem [FifoDepth];
  logic [FifoPtrWidth-1:0] wp, rp;
  logic [FifoPtrWidth:0]   cnt;

  assign fifo_empty = (cnt == '0);
  assign fifo_pop   = rd_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (fifo_rst) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      fifo_rdata <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 1'b1;
      end
      if (fifo_pop) begin
        fifo_rdata <= mem[rp];
        rp         <= rp + 1'b1;
      end
      cnt <= cnt + {{FifoPtrWidth{1'b0}}, wr_en} - {{FifoPtrWidth{1'b0}}, fifo_pop};
    end
  end

  // Handshakes seen at the negedge complete at the following posedge.
  logic [35:0] got_q[$];
  int          pops = 0;
  int          pop_err = 0;

  always @(negedge clk) begin
    if (out_if.valid && out_if.ready) got_q.push_back({out_if.byte_en, out_if.word});
    if (rd_en) pops <= pops + 1;
    if (rd_en && fifo_empty) pop_err <= pop_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (!fifo_empty && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(fifo_empty), 64'd1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [31:0] w, input logic [3:0] be);
    int          n = 0;
    logic [35:0] item;
    while (got_q.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_seen"}, 64'(got_q.size() != 0), 64'd1);
    if (got_q.size() != 0) begin
      item = got_q.pop_front();
      check({name, "_word"}, 64'(item[31:0]), 64'(w));
      check({name, "_be"}, 64'(item[35:32]), 64'(be));
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] data;
    logic        flush;
    logic [31:0] exp_word;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int pops0;
    vecs[0] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'hF};
    vecs[1] = '{2, 32'h0000A2A1, 1'b1, 32'h0000A2A1, 4'h3};
    vecs[2] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7};
    vecs[3] = '{1, 32'h000000FF, 1'b1, 32'h000000FF, 4'h1};
    vecs[4] = '{4, 32'h87654321, 1'b1, 32'h87654321, 4'hF};

    rst          = 1'b1;
    fifo_rst     = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    flush        = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) tick();
    fifo_rst = 1'b0;

    // Reset state, with a byte waiting in the FIFO that must not be popped.
    pops0 = pops;
    write_byte(8'h11);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_word", 64'(out_if.word), 64'd0);
    check("rst_be", 64'(out_if.byte_en), 64'd0);
    rst = 1'b0;
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    expect_word("t1", 32'h44332211, 4'hF);
    check("t1_pops", 64'(pops - pops0), 64'd4);
    repeat (4) tick();

    for (int v = 0; v < 5; v++) begin
      pops0 = pops;
      for (int i = 0; i < vecs[v].n; i++) write_byte(vecs[v].data[8*i +: 8]);
      wait_drained($sformatf("vec%0d", v));
      if (vecs[v].flush) pulse_flush();
      expect_word($sformatf("vec%0d", v), vecs[v].exp_word, vecs[v].exp_be);
      check($sformatf("vec%0d_pops", v), 64'(pops - pops0), 64'(vecs[v].n));
      repeat (8) tick();
      check($sformatf("vec%0d_no_extra", v), 64'(got_q.size()), 64'd0);
    end

    // Flush with nothing held is dropped.
    pulse_flush();
    repeat (10) tick();
    check("t3_empty_flush_words", 64'(got_q.size()), 64'd0);
    check("t3_empty_flush_valid", 64'(out_if.valid), 64'd0);

    // Sixteen bytes back-to-back.
    pops0 = pops;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    expect_word("t2_w0", 32'h03020100, 4'hF);
    expect_word("t2_w1", 32'h07060504, 4'hF);
    expect_word("t2_w2", 32'h0B0A0908, 4'hF);
    expect_word("t2_w3", 32'h0F0E0D0C, 4'hF);
    check("t2_pops", 64'(pops - pops0), 64'd16);
    repeat (4) tick();

    // Back-pressure: first word stalls in the slot, second stalls in assembly.
    out_if.ready = 1'b0;
    pops0 = pops;
    for (int i = 0; i < 12; i++) write_byte(8'h20 + 8'(i));
    repeat (30) tick();
    check("t4_valid", 64'(out_if.valid), 64'd1);
    check("t4_word", 64'(out_if.word), 64'h23222120);
    check("t4_pops_stalled", 64'(pops - pops0), 64'd8);
    check("t4_fifo_left", 64'(fifo_empty), 64'd0);
    repeat (5) tick();
    check("t4_word_stable", 64'(out_if.word), 64'h23222120);
    check("t4_no_accept", 64'(got_q.size()), 64'd0);
    out_if.ready = 1'b1;
    expect_word("t4_w0", 32'h23222120, 4'hF);
    expect_word("t4_w1", 32'h27262524, 4'hF);
    expect_word("t4_w2", 32'h2B2A2928, 4'hF);
    repeat (4) tick();

    // Flush in the same cycle as a pop with one byte already held.
    write_byte(8'h54);
    repeat (4) tick();
    write_byte(8'h55);
    check("t5_pop_now", 64'(rd_en), 64'd1);
    pulse_flush();
    expect_word("t5", 32'h00005554, 4'h3);
    repeat (8) tick();
    check("t5_no_extra", 64'(got_q.size()), 64'd0);

    // Reset with two bytes captured and a third in flight.
    write_byte(8'h61);
    write_byte(8'h62);
    write_byte(8'h63);
    wait_drained("t6");
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 64'(out_if.valid), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    check("t6_no_word", 64'(got_q.size()), 64'd0);
    write_byte(8'h71);
    write_byte(8'h72);
    write_byte(8'h73);
    write_byte(8'h74);
    expect_word("t6", 32'h74737271, 4'hF);

    repeat (4) tick();
    check("pop_while_empty", 64'(pop_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
